// File: rtl/reg_bank_pkg.sv
// Shared constants for the two-requester register bank arbiter.
// Holds the bank geometry, the arbiter FSM encoding and the selected-request payload.
package reg_bank_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;

  // Arbiter FSM encoding; LOCKi means requester i holds the bank.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOCK0 = 2'd1;
  localparam logic [1:0] ST_LOCK1 = 2'd2;

  // Fields of the requester that won arbiter this cycle.
  typedef struct packed {
    logic              we;
    logic              lock;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
  } bank_req_t;

endpackage

// File: rtl/reg_bank.sv
// DEPTH x WIDTH bank of load-enabled registers with a registered read port.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset (clears all entries and read data)
//   i_we       : write strobe; entry i_addr loads i_wdata on this edge
//   i_re       : read strobe; o_rdata captures entry i_addr on this edge
//   i_addr     : entry select for read or write
//   i_wdata    : write data
//   o_rdata    : registered read data
module reg_bank
  import reg_bank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata
);

  logic [WIDTH-1:0] w_q [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  // One load-enabled register per entry, loaded only when its address is decoded.
  for (genvar g = 0; g < DEPTH; g++) begin : g_reg
    logic             w_load;
    logic [WIDTH-1:0] r_q;

    assign w_load = i_we && (i_addr == ADDR_W'(g));

    always_ff @(posedge clk) begin
      if (!rst_n)      r_q <= '0;
      else if (w_load) r_q <= i_wdata;
    end

    assign w_q[g] = r_q;
  end

  // Registered read mux gives the one-cycle read latency.
  always_ff @(posedge clk) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_re) r_rdata <= w_q[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin, lockable arbiter sharing one register bank between two requesters.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   req_valid  : per-requester request valid
//   req_we     : per-requester write enable (0 = read)
//   req_lock   : keep the grant after this access
//   req_addr   : requester i address in [i*ADDR_W +: ADDR_W]
//   req_wdata  : requester i write data in [i*WIDTH +: WIDTH]
//   req_ready  : combinational grant, forced to 0 while rst_n is low
//   rsp_valid  : one-cycle read response pulse for requester i
//   rsp_rdata  : read data, meaningful while rsp_valid is nonzero
//   owner      : one-hot lock owner, 0 when unlocked
module reg_bank_arbiter
  import reg_bank_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_we,
  input  logic [1:0]            req_lock,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*WIDTH-1:0]    req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [WIDTH-1:0]      rsp_rdata,
  output logic [1:0]            owner
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_rr;
  logic [1:0] r_rsp_valid;
  logic [1:0] w_grant;
  logic       w_xfer;
  logic       w_sel;
  bank_req_t  w_req;

  // Grant: a lock restricts the bank to its owner; otherwise rr breaks ties.
  always_comb begin
    w_grant = 2'b00;
    case (r_state)
      ST_IDLE: begin
        if (req_valid == 2'b11) w_grant = r_rr ? 2'b10 : 2'b01;
        else                    w_grant = req_valid;
      end
      ST_LOCK0: w_grant = {1'b0, req_valid[0]};
      ST_LOCK1: w_grant = {req_valid[1], 1'b0};
      default:  w_grant = 2'b00;
    endcase
  end

  // Reset masks the grant immediately so nothing is accepted in a reset cycle.
  assign req_ready = w_grant & {2{rst_n}};
  assign w_xfer    = |req_ready;
  assign w_sel     = req_ready[1];

  // Mux the winning requester's fields.
  always_comb begin
    w_req.we    = req_we[w_sel];
    w_req.lock  = req_lock[w_sel];
    w_req.addr  = w_sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
    w_req.wdata = w_sel ? req_wdata[2*WIDTH-1:WIDTH]  : req_wdata[WIDTH-1:0];
  end

  // Lock FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_xfer && w_req.lock) w_state_nxt = w_sel ? ST_LOCK1 : ST_LOCK0;
      end
      ST_LOCK0, ST_LOCK1: begin
        if (w_xfer && !w_req.lock) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // After a transfer by requester i, the other requester gets priority.
  always_ff @(posedge clk) begin
    if (!rst_n)      r_rr <= 1'b0;
    else if (w_xfer) r_rr <= ~w_sel;
  end

  // Read response pulse tagged with the accepted requester.
  always_ff @(posedge clk) begin
    if (!rst_n)                   r_rsp_valid <= 2'b00;
    else if (w_xfer && !w_req.we) r_rsp_valid <= req_ready;
    else                          r_rsp_valid <= 2'b00;
  end

  reg_bank u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_xfer && w_req.we),
    .i_re    (w_xfer && !w_req.we),
    .i_addr  (w_req.addr),
    .i_wdata (w_req.wdata),
    .o_rdata (rsp_rdata)
  );

  assign rsp_valid = r_rsp_valid;
  assign owner     = {r_state == ST_LOCK1, r_state == ST_LOCK0};

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter: directed scenarios followed by
// randomized traffic, compared every cycle against a behavioural model.
module tb_reg_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_we, req_lock;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_ready, rsp_valid, owner;
  logic [15:0] rsp_rdata;

  reg_bank_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state.
  logic [15:0] m_mem [8];
  int          m_lock;       // -1 = unlocked, else owning requester
  int          m_rr;         // requester favoured when both are valid
  logic [1:0]  m_rv;         // expected rsp_valid
  logic [15:0] m_rd;         // expected rsp_rdata when m_rv != 0
  bit          m_after_rst;  // rsp_rdata must read 0 right after reset
  logic [1:0]  m_last_g;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] model_grant();
    if (!rst_n) return 2'b00;
    if (m_lock >= 0) return req_valid[m_lock] ? 2'(1 << m_lock) : 2'b00;
    if (req_valid == 2'b11) return (m_rr == 1) ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) m_mem[k] = 16'h0000;
    m_lock      = -1;
    m_rr        = 0;
    m_rv        = 2'b00;
    m_rd        = 16'h0000;
    m_after_rst = 1'b1;
  endtask

  // Check outputs mid-cycle, then apply one clock edge to DUT and model.
  task automatic cycle();
    logic [1:0] g;
    int         i;
    logic [2:0] a;
    #1;
    g = model_grant();
    m_last_g = g;
    chk("req_ready", req_ready, g);
    chk("owner", owner, (m_lock < 0) ? 2'b00 : 2'(1 << m_lock));
    chk("rsp_valid", rsp_valid, m_rv);
    if (m_rv != 2'b00 || m_after_rst) chk("rsp_rdata", rsp_rdata, m_rd);
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_after_rst = 1'b0;
      m_rv        = 2'b00;
      if (g != 2'b00) begin
        i = g[1] ? 1 : 0;
        a = req_addr[i*3 +: 3];
        if (req_we[i]) begin
          m_mem[a] = req_wdata[i*16 +: 16];
        end else begin
          m_rv = g;
          m_rd = m_mem[a];
        end
        m_rr = 1 - i;
        if (m_lock < 0 && req_lock[i])       m_lock = i;
        else if (m_lock == i && !req_lock[i]) m_lock = -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                       input logic [2:0] a0, input logic [2:0] a1,
                       input logic [15:0] d0, input logic [15:0] d1, input logic rst);
    req_valid = v;
    req_we    = we;
    req_lock  = lk;
    req_addr  = {a1, a0};
    req_wdata = {d1, d0};
    rst_n     = rst;
    cycle();
  endtask

  logic [1:0]  p_v, p_we, p_lk;
  logic [2:0]  p_a [2];
  logic [15:0] p_d [2];

  initial begin
    req_valid = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();

    // Reset state held for a checked cycle.
    drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0);

    // Write then read back by requester 0.
    drive(2'b01, 2'b01, 2'b00, 3'd3, 3'd0, 16'hAAAA, 16'h0, 1'b1);
    drive(2'b01, 2'b00, 2'b00, 3'd3, 3'd0, 16'h0, 16'h0, 1'b1);
    drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b1);

    // Contention from reset: req0 first, then req1.
    drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0);
    drive(2'b11, 2'b11, 2'b00, 3'd1, 3'd2, 16'h5555, 16'h1234, 1'b1);
    drive(2'b10, 2'b10, 2'b00, 3'd1, 3'd2, 16'h5555, 16'h1234, 1'b1);

    // Both read continuously: grants alternate.
    repeat (4) drive(2'b11, 2'b00, 2'b00, 3'd1, 3'd2, 16'h0, 16'h0, 1'b1);
    drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b1);

    // Lock: req1 locked read-modify-write of addr 5 while req0 waits.
    drive(2'b01, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b1);
    drive(2'b11, 2'b00, 2'b10, 3'd0, 3'd5, 16'h0, 16'h0, 1'b1);
    repeat (2) drive(2'b01, 2'b00, 2'b00, 3'd0, 3'd5, 16'h0, 16'h0, 1'b1);
    drive(2'b11, 2'b10, 2'b00, 3'd0, 3'd5, 16'h0, 16'hFFFF, 1'b1);
    drive(2'b01, 2'b00, 2'b00, 3'd5, 3'd0, 16'h0, 16'h0, 1'b1);
    drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b1);

    // Reset clears written data.
    drive(2'b01, 2'b01, 2'b00, 3'd7, 3'd0, 16'h00FF, 16'h0, 1'b1);
    drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0);
    drive(2'b01, 2'b00, 2'b00, 3'd7, 3'd0, 16'h0, 16'h0, 1'b1);
    drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b1);

    // Read presented during reset is dropped.
    drive(2'b01, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b0);
    drive(2'b00, 2'b00, 2'b00, 3'd0, 3'd0, 16'h0, 16'h0, 1'b1);

    // Randomized traffic; pending requests stay stable until accepted.
    p_v = 2'b00; p_we = 2'b00; p_lk = 2'b00;
    for (int r = 0; r < 2; r++) begin p_a[r] = 3'd0; p_d[r] = 16'h0; end
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_v[r] || m_last_g[r]) begin
          p_v[r]  = ($urandom_range(0, 99) < 60);
          p_we[r] = $urandom_range(0, 1) == 1;
          p_lk[r] = ($urandom_range(0, 99) < 20);
          p_a[r]  = 3'($urandom_range(0, 7));
          p_d[r]  = 16'($urandom);
        end
      end
      drive(p_v, p_we, p_lk, p_a[0], p_a[1], p_d[0], p_d[1],
            ($urandom_range(0, 63) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_bank_arbiter.md
Name: reg_bank_arbiter

Overview:
- Shares one bank of DEPTH x WIDTH load-enabled registers (Hack-style 16-bit registers) between two requesters.
- Round-robin arbitration, one access per cycle. Each port uses a valid/ready handshake, with a lock option for atomic read-modify-write sequences.
- Sits between CPU-side and DMA/IO-side masters and the shared register bank.

Parameters:
- WIDTH, 16, data width of each register.
- DEPTH, 8, number of registers; must equal 2**ADDR_W.
- ADDR_W, 3, address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_we  in  2  per-requester write enable; 0 = read.
- req_lock  in  2  hold the grant after this access (atomic sequence).
- req_addr  in  2*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  2*WIDTH  requester i write data in bits [i*WIDTH +: WIDTH].
- req_ready  out  2  access accepted this cycle (one-hot or zero).
- rsp_valid  out  2  read data valid for requester i.
- rsp_rdata  out  WIDTH  read data; meaningful only while rsp_valid is nonzero.
- owner  out  2  current lock owner, one-hot; 0 = unlocked.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all registers = 0.
  - req_ready = 0 combinationally, regardless of rst_n timing.
  - rsp_valid = 0, rsp_rdata = 0.
  - owner = 0, FSM = IDLE, round-robin pointer rr = 0 (requester 0 has priority).
- FSM states: IDLE, LOCK0, LOCK1. owner mirrors LOCK0 -> 2'b01, LOCK1 -> 2'b10.
- Grant is combinational from req_valid, FSM state and rr:
  - IDLE: if exactly one requester is valid, grant it. If both are valid, grant requester rr.
  - LOCKi: only requester i can be granted. The other requester sees req_ready=0 and must hold its request stable.
- req_ready[i] = grant[i]. A transfer occurs when req_valid[i] & req_ready[i].
- Write transfer: the register at addr takes wdata on the same clk edge. It is visible to any read accepted on the next cycle.
- Read transfer:
  - rsp_valid[i]=1 and rsp_rdata = reg[addr] on the cycle after acceptance (latency 1).
  - rsp_valid is a single-cycle pulse; there is no backpressure on responses.
- Read of an address written in the same cycle is impossible, since only one transfer happens per cycle.
- rr update: after any transfer by requester i, rr = ~i. If there is no transfer, rr is unchanged.
- Lock transitions:
  - IDLE -> LOCKi on a transfer by i with req_lock[i]=1.
  - LOCKi -> IDLE on a transfer by i with req_lock[i]=0. That transfer completes normally.
  - LOCKi persists while requester i is idle (req_valid[i]=0). There is no timeout.
- Back-to-back transfers by the same requester are allowed every cycle, provided the other requester is not valid or a lock is held.
- Reset mid-lock or mid-read: the next cycle is in IDLE with rsp_valid=0. A read accepted in the reset cycle is dropped.
- req_wdata is ignored on reads. req_addr is always in range because DEPTH == 2**ADDR_W.

Decomposition:
- Shared package reg_bank_pkg:
  - localparams WIDTH, DEPTH, ADDR_W.
  - FSM state encoding IDLE=2'd0, LOCK0=2'd1, LOCK1=2'd2.
- One sub-module, reg_bank: DEPTH instances of the existing 16-bit register with per-entry load decode and a registered read mux.
- Arbiter, FSM and response logic stay in reg_bank_arbiter.

Test Plan:
- Reset, then requester 0 writes addr 3 = 16'hAAAA; next cycle requester 0 reads addr 3 -> req_ready[0]=1 both cycles; rsp_valid=2'b01 with rsp_rdata=16'hAAAA one cycle after the read.
- Both requesters valid from reset; req0 writes addr 1=16'h5555, req1 writes addr 2=16'h1234 -> req0 granted first cycle, req1 second; later reads return 5555 and 1234.
- Both hold valid reads for 4 cycles -> grants alternate 0,1,0,1; rsp_valid alternates 01,10,01,10, each one cycle delayed.
- Req1 read addr 5 with lock=1, req0 valid continuously, then req1 write addr 5=16'hFFFF with lock=0 -> owner=2'b10 between the two accesses; req_ready[0]=0 throughout; owner returns to 0; req0 granted the next cycle.
- Write addr 7=16'h00FF, then assert rst_n=0 for one cycle, then read addr 7 -> owner=0, rsp_valid=0 after reset; read returns 16'h0000.
- Req0 reads addr 0 and rst_n=0 in the same cycle -> no rsp_valid in the following cycle.
